// File: rtl/gcd_stein_ctrl.sv
// Sequencer for the 8-bit binary (Stein) GCD unit.
// It drives the shared left/right shifter and performs one shift per clock.
module gcd_stein_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       sh_si,
    output logic       sh_l,
    output logic       sh_r,
    output logic [7:0] sh_in,
    input  logic [7:0] sh_out
);

    typedef enum logic [3:0] {
        IDLE,
        ZCHK,
        COMMON,
        COMMON_B,
        NORM_A,
        NORM_B,
        SUB,
        RESTORE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [2:0] k;
    logic       both_even;
    logic       rb_gt;
    logic [7:0] diff;

    assign sh_si     = 1'b0;
    assign both_even = ~ra[0] & ~rb[0];
    assign rb_gt     = rb > ra;
    // Both SUB branches leave the difference in rb.
    assign diff      = rb_gt ? (rb - ra) : (ra - rb);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and shifter/handshake decode
    always_comb begin
        state_nx = state;
        sh_l     = 1'b0;
        sh_r     = 1'b0;
        sh_in    = ra;
        busy     = (state != IDLE);
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = ZCHK;
            end
            ZCHK: begin
                if (ra == 8'd0 || rb == 8'd0)
                    state_nx = DONE;
                else
                    state_nx = COMMON;
            end
            COMMON: begin
                if (both_even) begin
                    sh_r     = 1'b1;
                    state_nx = COMMON_B;
                end else begin
                    state_nx = NORM_A;
                end
            end
            COMMON_B: begin
                sh_r     = 1'b1;
                sh_in    = rb;
                state_nx = COMMON;
            end
            NORM_A: begin
                if (!ra[0])
                    sh_r = 1'b1;
                else
                    state_nx = NORM_B;
            end
            NORM_B: begin
                if (!rb[0]) begin
                    sh_r  = 1'b1;
                    sh_in = rb;
                end else begin
                    state_nx = SUB;
                end
            end
            SUB: begin
                if (diff == 8'd0)
                    state_nx = RESTORE;
                else
                    state_nx = NORM_B;
            end
            RESTORE: begin
                if (k != 3'd0)
                    sh_l = 1'b1;
                else
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working operands, power-of-two count and result
    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= 8'd0;
            rb     <= 8'd0;
            k      <= 3'd0;
            result <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra <= a;
                        rb <= b;
                        k  <= 3'd0;
                    end
                end
                ZCHK: begin
                    if (ra == 8'd0)
                        result <= rb;
                    else if (rb == 8'd0)
                        result <= ra;
                end
                COMMON: begin
                    if (both_even)
                        ra <= sh_out;
                end
                COMMON_B: begin
                    rb <= sh_out;
                    k  <= k + 3'd1;
                end
                NORM_A: begin
                    if (!ra[0])
                        ra <= sh_out;
                end
                NORM_B: begin
                    if (!rb[0])
                        rb <= sh_out;
                end
                SUB: begin
                    if (!rb_gt)
                        ra <= rb;
                    rb <= diff;
                end
                RESTORE: begin
                    if (k != 3'd0) begin
                        ra <= sh_out;
                        k  <= k - 3'd1;
                    end else begin
                        result <= ra;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stein_ctrl.sv
// Bench for gcd_stein_ctrl: shifter model, scoreboard queue,
// protocol monitor and one task per scenario.
module tb_gcd_stein_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       sh_si;
    logic       sh_l;
    logic       sh_r;
    logic [7:0] sh_in;
    logic [7:0] sh_out;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    gcd_stein_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .sh_si  (sh_si),
        .sh_l   (sh_l),
        .sh_r   (sh_r),
        .sh_in  (sh_in),
        .sh_out (sh_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter model. Non-shift output is scrambled so any stray use of
    // sh_out outside a shift state corrupts the result.
    assign sh_out = sh_r ? {sh_si, sh_in[7:1]} :
                    sh_l ? {sh_in[6:0], sh_si} :
                    (sh_in ^ 8'hA5);

    function automatic logic [7:0] gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[7:0];
    endfunction

    // Protocol monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((sh_l & sh_r) !== 1'b0) begin
                errors++;
                $display("FAIL shl_shr_both got l=%b r=%b want not both", sh_l, sh_r);
            end
            checks++;
            if (sh_si !== 1'b0) begin
                errors++;
                $display("FAIL sh_si got %b want 0", sh_si);
            end
        end
    end

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got done=1 want no done (result=%0d)", result);
            end else begin
                logic [7:0] exp_r;
                exp_r = sb.pop_front();
                if (result !== exp_r) begin
                    errors++;
                    $display("FAIL result got %0d want %0d", result, exp_r);
                end
            end
        end
    end

    // Launch one run and wait (bounded) for done.
    task automatic run(input logic [7:0] x, input logic [7:0] y,
                       output int cyc, output int lsh, output bit busy_ok);
        sb.push_back(gcd_ref(int'(x), int'(y)));
        @(negedge clk);
        a       = x;
        b       = y;
        start   = 1'b1;
        cyc     = 0;
        lsh     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (sh_l === 1'b1) lsh++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (done !== 1'b1 && cyc < 80);
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        checks++;
        if (sh_l !== 1'b0 || sh_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_shift got l=%b r=%b want 0 0", sh_l, sh_r);
        end
        checks++;
        if (sh_in !== 8'd0) begin errors++; $display("FAIL reset_sh_in got %0d want 0", sh_in); end
    endtask

    task automatic test_zero;
        logic [7:0] xs[3] = '{8'd0, 8'd0, 8'd9};
        logic [7:0] ys[3] = '{8'd0, 8'd5, 8'd0};
        int cyc, lsh;
        bit bok;
        for (int i = 0; i < 3; i++) begin
            run(xs[i], ys[i], cyc, lsh, bok);
            checks++;
            if (cyc != 2) begin
                errors++;
                $display("FAIL zero_latency a=%0d b=%0d got %0d want 2", xs[i], ys[i], cyc);
            end
            checks++;
            if (!bok) begin errors++; $display("FAIL zero_busy got busy drop want busy=1"); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || result !== 8'd9) begin
                errors++;
                $display("FAIL idle_hold got busy=%b result=%0d want 0 9", busy, result);
            end
        end
    endtask

    task automatic test_common;
        int cyc, lsh;
        bit bok;
        run(8'd12, 8'd18, cyc, lsh, bok);
        checks++;
        if (lsh != 1) begin errors++; $display("FAIL common_k_12_18 got %0d want 1", lsh); end
        run(8'd128, 8'd64, cyc, lsh, bok);
        checks++;
        if (lsh != 6) begin errors++; $display("FAIL common_k_128_64 got %0d want 6", lsh); end
        checks++;
        if (cyc >= 64) begin errors++; $display("FAIL common_latency got %0d want <64", cyc); end
    endtask

    task automatic test_extremes;
        logic [7:0] xs[3] = '{8'd255, 8'd17, 8'd1};
        logic [7:0] ys[3] = '{8'd254, 8'd17, 8'd200};
        int cyc, lsh;
        bit bok;
        for (int i = 0; i < 3; i++) begin
            run(xs[i], ys[i], cyc, lsh, bok);
            checks++;
            if (cyc >= 64 || !bok) begin
                errors++;
                $display("FAIL extreme_run a=%0d b=%0d got cyc=%0d busy_ok=%b want <64 1",
                         xs[i], ys[i], cyc, bok);
            end
        end
    endtask

    task automatic test_random;
        int cyc, lsh;
        bit bok;
        logic [7:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            run(x, y, cyc, lsh, bok);
            checks++;
            if (cyc >= 64 || !bok) begin
                errors++;
                $display("FAIL random_run a=%0d b=%0d got cyc=%0d busy_ok=%b want <64 1",
                         x, y, cyc, bok);
            end
        end
    endtask

    task automatic test_hold_start;
        int cyc;
        sb.push_back(8'd6);
        @(negedge clk);
        a     = 8'd48;
        b     = 8'd18;
        start = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                a = 8'd255;
                b = 8'd1;
            end
        end while (done !== 1'b1 && cyc < 80);
        checks++;
        if (cyc >= 64) begin errors++; $display("FAIL hold_run1 got %0d want <64", cyc); end
        a = 8'd35;
        b = 8'd21;
        sb.push_back(8'd7);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle got busy=%b want 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL hold_restart got busy=%b want 1", busy); end
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 64) begin errors++; $display("FAIL hold_run2 got %0d want <64", cyc); end
    endtask

    task automatic test_reset_midrun;
        int cyc, lsh;
        bit bok;
        @(negedge clk);
        a     = 8'd96;
        b     = 8'd36;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (result !== 8'd0 || sh_l !== 1'b0 || sh_r !== 1'b0) begin
            errors++;
            $display("FAIL midrun_regs got result=%0d l=%b r=%b want 0 0 0", result, sh_l, sh_r);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_quiet got busy=%b done=%b want 0 0", busy, done);
            end
        end
        run(8'd96, 8'd36, cyc, lsh, bok);
        checks++;
        if (cyc >= 64) begin errors++; $display("FAIL midrun_rerun got %0d want <64", cyc); end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_common;
        test_extremes;
        test_random;
        test_hold_start;
        test_reset_midrun;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
